// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and constants for the PC sequencer
package pc_sequencer_pkg;

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    typedef enum logic [1:0] {
        S_RUN  = RUN,
        S_WAIT = WAIT,
        S_HALT = HALT
    } state_t;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam int          FLUSH_CNT_W      = 3;

endpackage

// File: rtl/pc_flush_counter.sv
// rtl/pc_flush_counter.sv - post-redirect flush down-counter with nonzero flag
//
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   load       : redirect accepted this cycle; reload with LOAD_VALUE
//   active     : counter nonzero (drives the squash output)
module pc_flush_counter
    import pc_sequencer_pkg::*;
#(
    parameter logic [FLUSH_CNT_W-1:0] LOAD_VALUE = 3'd1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic active
);

    logic [FLUSH_CNT_W-1:0] count;

    // Load has priority so a redirect during an active flush restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign active = (count != '0);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - architectural PC register and fetch sequencing FSM
//
// Ports:
//   clk, rst_n      : clock and synchronous active-low reset
//   pc_o            : current fetch PC (imem address, PC computation unit input)
//   fetch_req_o     : fetch request, low only when halted
//   imem_ready_i    : instruction at pc_o returned this cycle
//   pc_next_i       : PC+2 or PC-relative target from the PC computation unit
//   branch_taken_i  : PC-relative branch taken
//   br_reg_i        : register-indirect branch, target on br_target_i
//   br_target_i     : register-indirect branch target
//   stall_i         : hazard hold request
//   halt_i          : HLT decoded at pc_o
//   flush_o         : squash younger instructions after a redirect
//   halted_o        : processor halted
//   cyc_cnt_o       : saturating cycle count since reset
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc_o,
    output logic        fetch_req_o,
    input  logic        imem_ready_i,
    input  logic [15:0] pc_next_i,
    input  logic        branch_taken_i,
    input  logic        br_reg_i,
    input  logic [15:0] br_target_i,
    input  logic        stall_i,
    input  logic        halt_i,
    output logic        flush_o,
    output logic        halted_o,
    output logic [15:0] cyc_cnt_o
);

    state_t      state, state_nxt;
    logic [15:0] pc_nxt;
    logic        redirect;
    logic        flushing;

    pc_flush_counter #(
        .LOAD_VALUE (FLUSH_CNT_W'(FLUSH_CYCLES))
    ) u_flush (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (redirect),
        .active (flushing)
    );

    assign flush_o     = flushing;
    assign fetch_req_o = (state != S_HALT);

    // Decision priority: halt (unless squashed by a flush), BR, taken
    // branch, hold, sequential advance. Redirects ignore stall and imem wait.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_o;
        redirect  = 1'b0;
        if (state != S_HALT) begin
            if (halt_i && !flushing) begin
                state_nxt = S_HALT;
            end else if (br_reg_i) begin
                pc_nxt    = br_target_i;
                redirect  = 1'b1;
                state_nxt = S_RUN;
            end else if (branch_taken_i) begin
                pc_nxt    = pc_next_i;
                redirect  = 1'b1;
                state_nxt = S_RUN;
            end else if (stall_i || !imem_ready_i) begin
                state_nxt = imem_ready_i ? S_RUN : S_WAIT;
            end else begin
                pc_nxt    = pc_next_i;
                state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_RUN;
            pc_o      <= RESET_PC;
            halted_o  <= 1'b0;
            cyc_cnt_o <= '0;
        end else begin
            state    <= state_nxt;
            pc_o     <= pc_nxt;
            halted_o <= (state_nxt == S_HALT);
            if (state != S_HALT && cyc_cnt_o != 16'hFFFF) begin
                cyc_cnt_o <= cyc_cnt_o + 16'd1;
            end
        end
    end

endmodule
